// File: rtl/binary_to_gray.sv
// rtl/binary_to_gray.sv - parameterised binary-to-Gray converter with registered, self-monitoring path
//
// Purpose: converts an unsigned binary code to Gray code. A combinational
// output serves asynchronous consumers; a valid-qualified registered copy
// feeds a round-trip decode and a step monitor that flags any pair of
// consecutive (+/-1) samples whose Gray codes do not differ in exactly one bit.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   binary     binary code to convert
//   in_valid   qualifies binary for the registered path
//   gray       combinational Gray code of binary
//   gray_q     registered Gray code of the last accepted sample
//   out_valid  one-cycle pulse: gray_q updated this cycle
//   bin_rt     combinational Gray-to-binary decode of gray_q
//   step_bits  popcount of gray_q ^ previous gray_q
//   seq_step   last two accepted samples differ by +/-1 (mod 2^WIDTH)
//   step_err   sticky: a +/-1 step did not change exactly one Gray bit

module binary_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           binary,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           gray,
  output logic [WIDTH-1:0]           gray_q,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           bin_rt,
  output logic [$clog2(WIDTH+1)-1:0] step_bits,
  output logic                       seq_step,
  output logic                       step_err
);

  localparam int SW = $clog2(WIDTH+1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] gray_d;
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
  logic             out_valid_q, out_valid_d;
  logic             seq_step_q, seq_step_d;
  logic             step_err_q, step_err_d;
  logic             first_seen_q, first_seen_d;
  logic             step_bad;

  // Pure combinational path: valid even while rst_n is low.
  assign gray = binary ^ (binary >> 1);

  // Round-trip decode: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    bin_rt = '0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      acc       = acc ^ gray_q[i];
      bin_rt[i] = acc;
    end
  end

  always_comb begin
    logic [WIDTH-1:0] diff;
    diff      = gray_q ^ prev_gray_q;
    step_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      step_bits = step_bits + SW'(diff[i]);
    end
  end

  // The error is visible in the same cycle as the offending sample and then
  // held by the sticky flop.
  assign step_bad = out_valid_q && seq_step_q && (step_bits != SW'(1));
  assign step_err = step_err_q || step_bad;

  always_comb begin
    gray_d       = gray_q;
    prev_gray_d  = prev_gray_q;
    prev_bin_d   = prev_bin_q;
    out_valid_d  = 1'b0;
    seq_step_d   = seq_step_q;
    first_seen_d = first_seen_q;
    step_err_d   = step_err;
    if (in_valid) begin
      gray_d       = gray;
      prev_gray_d  = gray_q;
      prev_bin_d   = binary;
      out_valid_d  = 1'b1;
      // Comparison is WIDTH bits wide, so max+1 wraps to 0 and 0-1 to max.
      seq_step_d   = first_seen_q &&
                     ((binary == prev_bin_q + ONE) || (binary == prev_bin_q - ONE));
      first_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q       <= '0;
      prev_gray_q  <= '0;
      prev_bin_q   <= '0;
      out_valid_q  <= 1'b0;
      seq_step_q   <= 1'b0;
      step_err_q   <= 1'b0;
      first_seen_q <= 1'b0;
    end else begin
      gray_q       <= gray_d;
      prev_gray_q  <= prev_gray_d;
      prev_bin_q   <= prev_bin_d;
      out_valid_q  <= out_valid_d;
      seq_step_q   <= seq_step_d;
      step_err_q   <= step_err_d;
      first_seen_q <= first_seen_d;
    end
  end

  assign out_valid = out_valid_q;
  assign seq_step  = seq_step_q;

endmodule

// File: tb/tb_binary_to_gray.sv
// tb/tb_binary_to_gray.sv - self-checking bench for binary_to_gray

module tb_binary_to_gray;

  localparam int W  = 4;
  localparam int SW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  binary;
  logic          in_valid;
  logic [W-1:0]  gray;
  logic [W-1:0]  gray_q;
  logic          out_valid;
  logic [W-1:0]  bin_rt;
  logic [SW-1:0] step_bits;
  logic          seq_step;
  logic          step_err;

  binary_to_gray #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .binary    (binary),
    .in_valid  (in_valid),
    .gray      (gray),
    .gray_q    (gray_q),
    .out_valid (out_valid),
    .bin_rt    (bin_rt),
    .step_bits (step_bits),
    .seq_step  (seq_step),
    .step_err  (step_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] exp_gray;
  } vec_t;

  typedef struct {
    logic [W-1:0]  gray;
    logic [W-1:0]  bin;
    logic          seq;
    logic [SW-1:0] bits;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic         m_first;
  logic [W-1:0] m_prev_bin;
  logic [W-1:0] m_gray;
  logic [W-1:0] m_prev_gray;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W-1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  function automatic logic [SW-1:0] popcnt(input logic [W-1:0] v);
    logic [SW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) if (v[i]) c = c + 1'b1;
    return c;
  endfunction

  task automatic model_reset();
    m_first     = 1'b0;
    m_prev_bin  = '0;
    m_gray      = '0;
    m_prev_gray = '0;
  endtask

  // Drive one accepted sample, push its expectation, then compare on output.
  task automatic send(input logic [W-1:0] b);
    exp_t e;
    exp_t got;
    @(negedge clk);
    binary   = b;
    in_valid = 1'b1;
    e.gray = to_gray(b);
    e.bin  = b;
    e.seq  = m_first && ((b == W'(m_prev_bin + 1)) || (b == W'(m_prev_bin - 1)));
    e.bits = popcnt(e.gray ^ m_gray);
    m_prev_gray = m_gray;
    m_gray      = e.gray;
    m_prev_bin  = b;
    m_first     = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("out_valid", out_valid, 1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("gray_q", gray_q, got.gray);
      check("bin_rt", bin_rt, got.bin);
      check("seq_step", seq_step, got.seq);
      check("step_bits", step_bits, got.bits);
    end
    check("step_err", step_err, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("idle_out_valid", out_valid, 0);
      check("idle_gray_q", gray_q, m_gray);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] tbl[16];
    tbl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    for (int i = 0; i < 16; i++) begin
      vecs[i].bin      = W'(i);
      vecs[i].exp_gray = tbl[i];
    end

    rst_n    = 1'b0;
    in_valid = 1'b0;
    binary   = '0;
    model_reset();
    #3;
    check("rst_gray_q", gray_q, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_seq_step", seq_step, 0);
    check("rst_step_err", step_err, 0);
    check("rst_bin_rt", bin_rt, 0);
    check("rst_step_bits", step_bits, 0);

    // Combinational conversion, exercised while held in reset.
    for (int i = 0; i < 16; i++) begin
      binary = vecs[i].bin;
      #10;
      check("comb_gray", gray, vecs[i].exp_gray);
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Count-up, then wrap 15 -> 0, then count-down 0 -> 15.
    for (int i = 0; i < 16; i++) send(W'(i));
    send(4'd0);
    send(4'd15);

    // Non-sequential jump.
    send(4'd3);
    send(4'd12);

    // Hold, then repeat a sample.
    idle(3);
    send(4'd7);
    send(4'd7);
    idle(1);

    // Asynchronous reset between clock edges.
    send(4'd8);
    send(4'd9);
    @(negedge clk);
    in_valid = 1'b0;
    binary   = 4'd6;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gray_q", gray_q, 0);
    check("async_out_valid", out_valid, 0);
    check("async_seq_step", seq_step, 0);
    check("async_step_err", step_err, 0);
    check("async_bin_rt", bin_rt, 0);
    check("async_gray_tracks", gray, to_gray(4'd6));
    binary = 4'd13;
    #1;
    check("async_gray_tracks2", gray, to_gray(4'd13));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(4'd5);
    send(4'd4);
    send(4'd3);

    @(negedge clk);
    in_valid = 1'b0;
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
